// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared constants for the memory-mapped I/O port: datapath
//               width, FIFO depth, status-word bit positions and the OUT/IN
//               addresses decoded by the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  // Datapath and buffering
  localparam int WORD_W   = 16;
  localparam int IO_DEPTH = 4;

  // Status word layout: {pad, tx_ovf, rx_unf, tx_full, rx_empty, tx_cnt, rx_cnt}
  localparam int ST_TX_OVF   = 7;
  localparam int ST_RX_UNF   = 6;
  localparam int ST_TX_FULL  = 5;
  localparam int ST_RX_EMPTY = 4;
  localparam int ST_TX_CNT   = 2;   // LSB of the tx occupancy field
  localparam int ST_RX_CNT   = 0;   // LSB of the rx occupancy field
  localparam int ST_CNT_W    = 2;   // width of each occupancy field

  // Port addresses shared with the data memory decoder
  localparam logic [WORD_W-1:0] ADDR_OUT = 16'hFFFE;
  localparam logic [WORD_W-1:0] ADDR_IN  = 16'hFFFF;

endpackage : mmio_pkg
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Small synchronous FIFO with registered pointers and an
//               occupancy count. A push while full is accepted only when a pop
//               happens in the same cycle. The head word reads as zero when
//               the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active low
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Flags come straight from the count register
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop needs data; a push into a full FIFO needs the slot a pop frees
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head word, forced to zero when nothing is buffered
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : io_fifo
`default_nettype wire

// File: rtl/mmio_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_port_responder
// Description : Device-side responder for the memory-mapped I/O port. CPU
//               stores to OUT are queued in a TX FIFO drained by an external
//               device over valid/ready; device words are queued in an RX FIFO
//               whose head is read by CPU loads of IN. Sticky overflow and
//               underflow flags plus a status word allow polling.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = IO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active low
  input  logic [WIDTH-1:0] cpu_out,
  input  logic             cpu_out_we,
  output logic [WIDTH-1:0] cpu_in,
  input  logic             cpu_in_rd,
  output logic [WIDTH-1:0] cpu_status,
  input  logic             err_clr,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);

  logic [AW:0] tx_cnt;
  logic [AW:0] rx_cnt;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_full;
  logic        rx_empty;
  logic        tx_pop;
  logic        rx_push;
  logic        tx_ovf;
  logic        rx_unf;
  logic        tx_ovf_set;
  logic        rx_unf_set;

  // Handshake glue: rx_ready depends only on stored occupancy, so a CPU read
  // in the same cycle never opens a combinational path to the device
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;

  // A store is lost only when the FIFO is full and nothing leaves this cycle
  assign tx_ovf_set = cpu_out_we && tx_full && !tx_pop;
  assign rx_unf_set = cpu_in_rd && rx_empty;

  io_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cpu_out_we),
    .pop   (tx_pop),
    .wdata (cpu_out),
    .rdata (tx_data),
    .count (tx_cnt),
    .full  (tx_full),
    .empty (tx_empty)
  );

  io_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (cpu_in_rd),
    .wdata (rx_data),
    .rdata (cpu_in),
    .count (rx_cnt),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Sticky error flags; a clear wins over a simultaneous set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else if (err_clr) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_ovf_set) begin
        tx_ovf <= 1'b1;
      end
      if (rx_unf_set) begin
        rx_unf <= 1'b1;
      end
    end
  end

  // Status word assembled from registered state only; a full FIFO shows its
  // occupancy field as zero with the full flag set
  always_comb begin
    cpu_status                             = '0;
    cpu_status[ST_TX_OVF]                  = tx_ovf;
    cpu_status[ST_RX_UNF]                  = rx_unf;
    cpu_status[ST_TX_FULL]                 = tx_full;
    cpu_status[ST_RX_EMPTY]                = rx_empty;
    cpu_status[ST_TX_CNT +: ST_CNT_W]      = ST_CNT_W'(tx_cnt);
    cpu_status[ST_RX_CNT +: ST_CNT_W]      = ST_CNT_W'(rx_cnt);
  end

endmodule : mmio_port_responder
`default_nettype wire
